// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported, byte-wide unified instruction/data memory between
// the fetch stage and the memory stage of a Y86 pipeline. A fetch
// (IF_BYTES bytes), a data read or a data write (DM_BYTES bytes) is broken
// into one memory access per cycle. Multi-byte values are big-endian: the
// byte at the lowest address is the most significant one.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-low reset
//   if_req     fetch request, held high until if_done
//   if_addr    fetch base address
//   if_inst    fetched bytes, byte at if_addr in the top byte
//   if_done    one-cycle fetch completion pulse
//   dm_req     data request, held high until dm_done
//   dm_we      1 = write, 0 = read
//   dm_addr    data base address
//   dm_wdata   write data, top byte goes to dm_addr
//   dm_rdata   read data, byte at dm_addr in the top byte
//   dm_done    one-cycle data completion pulse
//   mem_en     memory access strobe
//   mem_we     memory write strobe (qualified by mem_en)
//   mem_addr   memory byte address
//   mem_wdata  memory write byte
//   mem_rdata  memory read byte, valid the cycle after a read strobe
//   busy       high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int IF_BYTES = 6,
  parameter int DM_BYTES = 4,
  parameter int ADDR_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [8*IF_BYTES-1:0] if_inst,
  output logic                  if_done,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_W-1:0]     dm_addr,
  input  logic [8*DM_BYTES-1:0] dm_wdata,
  output logic [8*DM_BYTES-1:0] dm_rdata,
  output logic                  dm_done,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  busy
);

  localparam int BUF_W = 8 * IF_BYTES;
  localparam int DW    = 8 * DM_BYTES;
  // Counter must reach IF_BYTES (the extra capture-only cycle of a fetch).
  localparam int CNT_W = $clog2(IF_BYTES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] IF_LAST = CNT_W'(IF_BYTES);
  localparam logic [CNT_W-1:0] DM_LAST = CNT_W'(DM_BYTES);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(DM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IF_RD = 3'd1,
    DM_RD = 3'd2,
    DM_WR = 3'd3,
    RESP  = 3'd4
  } state_e;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_e;

  state_e              state_q,      state_d;
  grant_e              last_grant_q, last_grant_d;
  logic                we_q,         we_d;
  logic [ADDR_W-1:0]   base_q,       base_d;
  logic [DW-1:0]       wdata_q,      wdata_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic [BUF_W-1:0]    rd_buf_q,     rd_buf_d;
  logic [BUF_W-1:0]    if_inst_q,    if_inst_d;
  logic [DW-1:0]       dm_rdata_q,   dm_rdata_d;
  logic                if_done_q,    if_done_d;
  logic                dm_done_q,    dm_done_d;
  logic                mem_en_q,     mem_en_d;
  logic                mem_we_q,     mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
  logic [7:0]          mem_wdata_q,  mem_wdata_d;
  logic                busy_q,       busy_d;

  logic                grant_data_s;
  logic [CNT_W-1:0]    rd_last_s;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic [ADDR_W-1:0]   addr_next_s;

  // Next-state, datapath and registered-output logic for the access FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rd_buf_d     = rd_buf_q;
    if_inst_d    = if_inst_q;
    dm_rdata_d   = dm_rdata_q;
    if_done_d    = 1'b0;
    dm_done_d    = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = 8'h00;
    grant_data_s = 1'b0;
    rd_last_s    = IF_LAST;
    cnt_inc_s    = cnt_q + CNT_ONE;
    // Address of the byte issued in the next cycle; wraps modulo 2^ADDR_W.
    addr_next_s  = base_q + ADDR_W'(cnt_inc_s);

    case (state_q)
      IDLE: begin
        // On a tie the port that did not win last time gets the memory.
        if (if_req && dm_req) begin
          grant_data_s = (last_grant_q == GNT_FETCH);
        end else begin
          grant_data_s = dm_req;
        end

        if (if_req || dm_req) begin
          // Byte 0 is issued in the first cycle of the new state.
          cnt_d    = '0;
          rd_buf_d = '0;
          mem_en_d = 1'b1;
          if (grant_data_s) begin
            last_grant_d = GNT_DATA;
            we_d         = dm_we;
            base_d       = dm_addr;
            mem_addr_d   = dm_addr;
            // Only the bytes still to be written are kept, MSB-aligned.
            wdata_d      = {dm_wdata[DW-9:0], 8'h00};
            if (dm_we) begin
              state_d     = DM_WR;
              mem_we_d    = 1'b1;
              mem_wdata_d = dm_wdata[DW-1 -: 8];
            end else begin
              state_d     = DM_RD;
            end
          end else begin
            last_grant_d = GNT_FETCH;
            we_d         = 1'b0;
            base_d       = if_addr;
            mem_addr_d   = if_addr;
            state_d      = IF_RD;
          end
        end else begin
          state_d = IDLE;
        end
      end

      IF_RD, DM_RD: begin
        if (state_q == DM_RD) begin
          rd_last_s = DM_LAST;
        end else begin
          rd_last_s = IF_LAST;
        end

        // Read data lags the strobe by a cycle; shifting in from the bottom
        // leaves the first (lowest-address) byte most significant.
        if (cnt_q != '0) begin
          rd_buf_d = {rd_buf_q[BUF_W-9:0], mem_rdata};
        end else begin
          rd_buf_d = rd_buf_q;
        end

        if (cnt_q == rd_last_s) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s != rd_last_s) begin
            mem_en_d   = 1'b1;
            mem_addr_d = addr_next_s;
          end else begin
            mem_en_d   = 1'b0;
          end
        end
      end

      DM_WR: begin
        if (cnt_q == WR_LAST) begin
          state_d = RESP;
        end else begin
          cnt_d       = cnt_inc_s;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_next_s;
          mem_wdata_d = wdata_q[DW-1 -: 8];
          wdata_d     = {wdata_q[DW-9:0], 8'h00};
        end
      end

      RESP: begin
        state_d = IDLE;
        // Results become visible together with the done pulse.
        if (last_grant_q == GNT_FETCH) begin
          if_done_d = 1'b1;
          if_inst_d = rd_buf_q;
        end else begin
          dm_done_d = 1'b1;
          if (!we_q) begin
            dm_rdata_d = rd_buf_q[DW-1:0];
          end else begin
            dm_rdata_d = dm_rdata_q;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transaction immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_FETCH;
      we_q         <= 1'b0;
      base_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rd_buf_q     <= '0;
      if_inst_q    <= '0;
      dm_rdata_q   <= '0;
      if_done_q    <= 1'b0;
      dm_done_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 8'h00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rd_buf_q     <= rd_buf_d;
      if_inst_q    <= if_inst_d;
      dm_rdata_q   <= dm_rdata_d;
      if_done_q    <= if_done_d;
      dm_done_q    <= dm_done_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign if_inst   = if_inst_q;
  assign if_done   = if_done_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_done   = dm_done_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A synchronous byte memory (1 KiB,
// addresses alias on the low 10 bits) sits behind the arbiter. A reference
// model tracks memory contents, the tie-break history and the expected
// completion cycle of every request, computed from the transaction rules.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int IF_BYTES = 6;
  localparam int DM_BYTES = 4;
  localparam int ADDR_W   = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [47:0] if_inst;
  logic [31:0] dm_rdata;
  logic        if_done, dm_done, mem_en, mem_we, busy;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  always #5 clk = ~clk;

  mem_arbiter #(.IF_BYTES(IF_BYTES), .DM_BYTES(DM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Environment memory (driven by the DUT) and reference memory (model).
  logic [7:0]  env_mem [1024] = '{default: 8'h00};
  logic [7:0]  ref_mem [1024] = '{default: 8'h00};
  logic [32:0] strobe_q [$];

  int          n_checks = 0;
  int          n_errors = 0;
  bit          last_ref_data = 1'b0;
  logic [47:0] exp_inst = '0;
  logic [31:0] exp_rdata = '0;

  // Synchronous byte memory plus a log of every strobe {we, addr}.
  always @(posedge clk) begin
    if (mem_en) begin
      strobe_q.push_back({mem_we, mem_addr});
      if (mem_we) env_mem[mem_addr[9:0]] <= mem_wdata;
      else        mem_rdata <= env_mem[mem_addr[9:0]];
    end
  end

  function automatic logic [9:0] idx(input logic [31:0] a);
    return a[9:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_if_inst"},  if_inst,   0);
    chk({tag, "_dm_rdata"}, dm_rdata,  0);
    chk({tag, "_if_done"},  if_done,   0);
    chk({tag, "_dm_done"},  dm_done,   0);
    chk({tag, "_mem_en"},   mem_en,    0);
    chk({tag, "_mem_we"},   mem_we,    0);
    chk({tag, "_mem_addr"}, mem_addr,  0);
    chk({tag, "_mem_wd"},   mem_wdata, 0);
    chk({tag, "_busy"},     busy,      0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    #1;
    chk_zero(tag);
    exp_inst = '0; exp_rdata = '0; last_ref_data = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One fetch and/or one data request raised together; checks done timing,
  // results, strobe sequence and written bytes against the model.
  task automatic run_txn(input bit f, input bit d, input logic [31:0] fa,
                         input logic [31:0] da, input bit we, input logic [31:0] wd);
    bit          data_first;
    int          lat_dm, gk_if, gk_dm, dk_if, dk_dm, k_end, s0;
    logic [47:0] e_i;
    logic [31:0] e_r;
    logic [31:0] a;
    logic [32:0] exp_s [$];

    data_first = d && (!f || !last_ref_data);
    lat_dm = we ? 5 : 6;
    gk_if = -1; gk_dm = -1; dk_if = -1; dk_dm = -1;
    if (data_first) begin
      gk_dm = 0; dk_dm = lat_dm;
      if (f) begin gk_if = dk_dm + 1; dk_if = gk_if + 8; end
    end else begin
      gk_if = 0; dk_if = 8;
      if (d) begin gk_dm = 9; dk_dm = gk_dm + lat_dm; end
    end
    last_ref_data = (f && d) ? !data_first : d;

    e_i = exp_inst; e_r = exp_rdata;
    for (int s = 0; s < 2; s++) begin
      if ((s == 0) == data_first) begin
        if (d) begin
          for (int i = 0; i < DM_BYTES; i++) begin
            a = da + 32'(i);
            exp_s.push_back({we, a});
            if (we) ref_mem[idx(a)] = wd[31 - 8*i -: 8];
            else    e_r = {e_r[23:0], ref_mem[idx(a)]};
          end
        end
      end else begin
        if (f) begin
          for (int i = 0; i < IF_BYTES; i++) begin
            a = fa + 32'(i);
            exp_s.push_back({1'b0, a});
            e_i = {e_i[39:0], ref_mem[idx(a)]};
          end
        end
      end
    end
    exp_inst = e_i; exp_rdata = e_r;
    k_end = ((dk_if > dk_dm) ? dk_if : dk_dm) + 1;

    @(negedge clk);
    s0 = strobe_q.size();
    if_req = f; if_addr = fa;
    dm_req = d; dm_we = we; dm_addr = da; dm_wdata = wd;

    for (int k = 0; k <= k_end; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("if_done", if_done, k == dk_if);
      chk("dm_done", dm_done, k == dk_dm);
      if (k == gk_if || k == gk_dm) chk("busy_grant", busy, 1);
      if (k == dk_if || k == dk_dm) begin
        chk("busy_done", busy, 0);
        chk("mem_en_done", mem_en, 0);
      end
      if (k == dk_if) begin chk("if_inst", if_inst, exp_inst); if_req = 1'b0; end
      if (k == dk_dm) begin chk("dm_rdata", dm_rdata, exp_rdata); dm_req = 1'b0; end
      // Inputs of a granted port are scrambled; latched copies must win.
      if (f && k >= gk_if && k < dk_if) if_addr = $urandom;
      if (d && k >= gk_dm && k < dk_dm) begin
        dm_addr = $urandom; dm_wdata = $urandom; dm_we = 1'($urandom_range(0, 1));
      end
    end
    if_req = 1'b0; dm_req = 1'b0;

    chk("n_strobes", strobe_q.size() - s0, exp_s.size());
    for (int i = 0; i < exp_s.size(); i++) begin
      if (s0 + i < strobe_q.size()) chk("strobe", strobe_q[s0 + i], exp_s[i]);
    end
    if (d && we) begin
      for (int i = 0; i < DM_BYTES; i++) begin
        a = da + 32'(i);
        chk("wr_byte", env_mem[idx(a)], ref_mem[idx(a)]);
      end
    end
    chk("if_inst_hold", if_inst, exp_inst);
    chk("dm_rdata_hold", dm_rdata, exp_rdata);
  endtask

  // Tie from reset: data wins; data re-requests at once, fetch now wins.
  task automatic tie_alt();
    logic [47:0] e_i = '0;
    logic [31:0] e_r1 = '0;
    logic [31:0] e_r2 = '0;
    for (int i = 0; i < IF_BYTES; i++) e_i = {e_i[39:0], ref_mem[idx(32'(i))]};
    for (int i = 0; i < DM_BYTES; i++) begin
      e_r1 = {e_r1[23:0], ref_mem[idx(32'h100 + 32'(i))]};
      e_r2 = {e_r2[23:0], ref_mem[idx(32'h104 + 32'(i))]};
    end
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    for (int k = 0; k <= 23; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("alt_if_done", if_done, k == 15);
      chk("alt_dm_done", dm_done, k == 6 || k == 22);
      if (k == 6)  begin chk("alt_rd1", dm_rdata, e_r1); dm_addr = 32'h104; end
      if (k == 15) begin chk("alt_inst", if_inst, e_i); if_req = 1'b0; end
      if (k == 22) begin chk("alt_rd2", dm_rdata, e_r2); dm_req = 1'b0; end
    end
    if_req = 1'b0; dm_req = 1'b0;
    exp_inst = e_i; exp_rdata = e_r2; last_ref_data = 1'b1;
  endtask

  // Reset asserted after two bytes of a write have reached memory.
  task automatic reset_abort();
    logic [31:0] a = 32'h300;
    logic [31:0] w = 32'hA1B2C3D4;
    int          s0;
    @(negedge clk);
    s0 = strobe_q.size();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = a; dm_wdata = w;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; dm_req = 1'b0;
    #1;
    chk_zero("abort");
    ref_mem[idx(a)] = w[31:24];
    ref_mem[idx(a + 32'd1)] = w[23:16];
    exp_inst = '0; exp_rdata = '0; last_ref_data = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", dm_done, 0);
      chk("abort_idle", busy, 0);
    end
    rst = 1'b1;
    chk("abort_strobes", strobe_q.size() - s0, 2);
    for (int i = 0; i < DM_BYTES; i++) begin
      chk("abort_mem", env_mem[idx(a + 32'(i))], ref_mem[idx(a + 32'(i))]);
    end
  endtask

  initial begin
    logic [7:0] tp_bytes [4];
    bit          f, d, w;
    logic [31:0] fa, da, wd;

    tp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    #1 rst = 1'b0;
    #1 chk_zero("por");
    @(negedge clk);
    rst = 1'b1;

    // Program bytes 0..5 = 30 F0 0A 00 00 00, then fetch them.
    run_txn(1'b0, 1'b1, 32'h0, 32'h2, 1'b1, 32'h0A000000);
    run_txn(1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 32'h30F00A00);
    run_txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("tp_fetch", if_inst, 48'h30F00A000000);

    // Write then read back.
    run_txn(1'b0, 1'b1, 32'h0, 32'h100, 1'b1, 32'h11223344);
    for (int i = 0; i < 4; i++) chk("tp_wr_bytes", env_mem[idx(32'h100 + 32'(i))], tp_bytes[i]);
    run_txn(1'b0, 1'b1, 32'h0, 32'h100, 1'b0, 32'h0);
    chk("tp_read", dm_rdata, 32'h11223344);

    // Ties and alternation.
    do_reset("rst1");
    tie_alt();
    run_txn(1'b1, 1'b1, 32'h10, 32'h104, 1'b1, 32'hDEADBEEF);
    run_txn(1'b1, 1'b1, 32'h20, 32'h108, 1'b0, 32'h0);

    // Address wrap.
    run_txn(1'b1, 1'b0, 32'hFFFFFFFE, 32'h0, 1'b0, 32'h0);
    run_txn(1'b0, 1'b1, 32'h0, 32'hFFFFFFFE, 1'b1, 32'hCAFEF00D);

    reset_abort();
    run_txn(1'b1, 1'b1, 32'h300, 32'h300, 1'b0, 32'h0);

    for (int t = 0; t < 30; t++) begin
      f = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      if (!f && !d) f = 1'b1;
      w = 1'($urandom_range(0, 1));
      fa = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFA + $urandom_range(0, 5) : $urandom_range(0, 1023);
      da = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3) : $urandom_range(0, 1023);
      wd = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(f, d, fa, da, w, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
